// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the 12-bit-instruction core sequencer.
//   NOP_INSTR     : instruction word presented to the decoder during bubbles/sleep
//   RESET_VEC_DEF : default first fetch address after reset
//   GOTO_TGT_W    : width of the GOTO target field in the instruction word
//   CALL_TGT_W    : width of the CALL target field in the instruction word
//   seq_state_e   : RUN/SLEEP state of the sequencer
package instr_sequencer_pkg;

  localparam logic [11:0] NOP_INSTR     = 12'h000;
  localparam logic [10:0] RESET_VEC_DEF = 11'h7FF;
  localparam int          GOTO_TGT_W    = 9;
  localparam int          CALL_TGT_W    = 8;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SLEEP = 1'b1
  } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the fetch/execute sequencer and its environment (program ROM,
// instruction decoder, datapath, wake logic).
//   master : the sequencer side (drives fetch address, instruction to decoder,
//            exec_valid, sleep status and debug PC)
//   slave  : the environment side (drives ROM data, decoder/datapath feedback,
//            page bits and wake request)
interface instr_sequencer_if #(
  parameter int PC_W = 11
) ();

  logic [PC_W-1:0] prog_addr;
  logic [11:0]     instr_in;
  logic [11:0]     instr_out;
  logic            exec_valid;
  logic            goto_i;
  logic            call_i;
  logic            retlw_i;
  logic            sleep_i;
  logic            skip_i;
  logic            pcl_wr_i;
  logic [7:0]      pcl_data_i;
  logic [1:0]      page_i;
  logic            wake_i;
  logic            sleeping_o;
  logic [PC_W-1:0] pc_o;

  modport master (
    output prog_addr, instr_out, exec_valid, sleeping_o, pc_o,
    input  instr_in, goto_i, call_i, retlw_i, sleep_i, skip_i,
           pcl_wr_i, pcl_data_i, page_i, wake_i
  );

  modport slave (
    input  prog_addr, instr_out, exec_valid, sleeping_o, pc_o,
    output instr_in, goto_i, call_i, retlw_i, sleep_i, skip_i,
           pcl_wr_i, pcl_data_i, page_i, wake_i
  );

endinterface

// File: rtl/instr_sequencer_call_stack.sv
// Two-entry hardware call stack (shift stack).
//   clk, rst     : clock, asynchronous active-high reset (both entries -> 0)
//   push_i       : stack2 <= stack1, stack1 <= push_data_i
//   pop_i        : stack1 <= stack2, stack2 keeps its value so that an
//                  underflowing return repeats the oldest entry
//   push_data_i  : return address to push
//   top_o        : current top of stack (stack1)
// A third nested push silently discards the oldest entry.
module call_stack
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic [PC_W-1:0] top_o
);

  logic [PC_W-1:0] stack1_q, stack1_d;
  logic [PC_W-1:0] stack2_q, stack2_d;

  always_comb begin
    stack1_d = stack1_q;
    stack2_d = stack2_q;
    if (push_i) begin
      stack2_d = stack1_q;
      stack1_d = push_data_i;
    end else if (pop_i) begin
      stack1_d = stack2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack1_q <= '0;
      stack2_q <= '0;
    end else begin
      stack1_q <= stack1_d;
      stack2_q <= stack2_d;
    end
  end

  assign top_o = stack1_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the 12-bit-instruction PIC-style core.
// Owns the program counter, the two-level call stack and the one-deep fetch
// pipeline, and tracks RUN/SLEEP.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_sequencer_if.master
//     prog_addr  -> synchronous ROM address (= PC register)
//     instr_in   <- ROM data, valid one cycle after prog_addr
//     instr_out  -> instruction to decoder, NOP when exec_valid is low
//     exec_valid -> instr_out is executing this cycle
//     goto/call/retlw/sleep/skip/pcl_wr/pcl_data/page <- decoder and datapath
//     wake_i     <- wake request, sampled only while asleep
//     sleeping_o -> core is in SLEEP
//     pc_o       -> debug copy of PC
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int              PC_W      = 11,
  parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEF
) (
  input logic                clk,
  input logic                rst,
  instr_sequencer_if.master  bus
);

  seq_state_e      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            exec_valid_q;
  logic            sleeping_q;

  logic            ctl_en;
  logic            redirect;
  logic            sleep_req;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] stack_top;

  // Decoder feedback only means something for a real instruction.
  assign ctl_en = exec_valid_q;
  assign pc_inc = pc_q + PC_W'(1);

  // Push the return address (already A+1 in the PC) and pop only for the
  // highest-priority redirect actually taken.
  assign push = ctl_en & ~bus.goto_i & bus.call_i;
  assign pop  = ctl_en & ~bus.goto_i & ~bus.call_i & bus.retlw_i;

  call_stack #(
    .PC_W(PC_W)
  ) u_call_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_q),
    .top_o       (stack_top)
  );

  // Next fetch address. A redirect throws away the already-fetched
  // fall-through word, so it also forces a bubble on the next cycle.
  always_comb begin
    pc_d     = pc_inc;
    redirect = 1'b0;
    if (ctl_en) begin
      if (bus.goto_i) begin
        pc_d     = PC_W'({bus.page_i, bus.instr_out[GOTO_TGT_W-1:0]});
        redirect = 1'b1;
      end else if (bus.call_i) begin
        pc_d     = PC_W'({bus.page_i, 1'b0, bus.instr_out[CALL_TGT_W-1:0]});
        redirect = 1'b1;
      end else if (bus.retlw_i) begin
        pc_d     = stack_top;
        redirect = 1'b1;
      end else if (bus.pcl_wr_i) begin
        pc_d     = PC_W'({bus.page_i, 1'b0, bus.pcl_data_i});
        redirect = 1'b1;
      end else if (bus.skip_i) begin
        redirect = 1'b1;
      end
    end
  end

  assign sleep_req = ctl_en & bus.sleep_i & ~redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_VEC;
      exec_valid_q <= 1'b0;
      sleeping_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (sleep_req) begin
            // PC stays at A+1 so the instruction after SLEEP runs on wake.
            state_q      <= ST_SLEEP;
            exec_valid_q <= 1'b0;
            sleeping_q   <= 1'b1;
          end else begin
            pc_q         <= pc_d;
            exec_valid_q <= ~redirect;
          end
        end
        ST_SLEEP: begin
          // Leaving SLEEP keeps exec_valid low one more cycle: the ROM word
          // at PC is re-fetched as the bubble, then executes.
          if (bus.wake_i) begin
            state_q    <= ST_RUN;
            sleeping_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          exec_valid_q <= 1'b0;
          sleeping_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_out  = exec_valid_q ? bus.instr_in : NOP_INSTR;
  assign bus.exec_valid = exec_valid_q;
  assign bus.prog_addr  = pc_q;
  assign bus.pc_o       = pc_q;
  assign bus.sleeping_o = sleeping_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: acts as program ROM, instruction decoder and
// wake source. A random program is loaded per run; an instruction-level
// model predicts the sequence of executed addresses/words and the bubble
// count before each, and a monitor pops that queue whenever exec_valid is high.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int PC_W = 11;

  typedef struct {
    logic [10:0] addr;
    logic [11:0] word;
    int          gap;   // idle cycles before this execute; -1 means after SLEEP
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  instr_sequencer_if #(.PC_W(PC_W)) bus ();

  instr_sequencer #(
    .PC_W      (PC_W),
    .RESET_VEC (11'h7FF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  logic [11:0] prog [0:2047];
  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        mon_en = 1'b0;
  logic [1:0]  page = 2'b00;
  logic        wake = 1'b0;
  logic [5:0]  noise_ctl = '0;
  logic [7:0]  noise_pcl = '0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ROM: synchronous read.
  always @(posedge clk) bus.instr_in <= prog[bus.prog_addr];

  // Decoder/datapath: decodes the presented instruction; while no real
  // instruction is presented it drives random junk that must be ignored.
  always_comb begin
    bus.goto_i     = noise_ctl[0];
    bus.call_i     = noise_ctl[1];
    bus.retlw_i    = noise_ctl[2];
    bus.skip_i     = noise_ctl[3];
    bus.pcl_wr_i   = noise_ctl[4];
    bus.sleep_i    = noise_ctl[5];
    bus.pcl_data_i = noise_pcl;
    if (bus.exec_valid) begin
      bus.goto_i     = (bus.instr_out[11:9] == 3'b101);
      bus.call_i     = (bus.instr_out[11:8] == 4'b1001);
      bus.retlw_i    = (bus.instr_out[11:8] == 4'b1000);
      bus.skip_i     = (bus.instr_out[11:8] == 4'b0111) && bus.instr_out[0];
      bus.pcl_wr_i   = (bus.instr_out == 12'h022);
      bus.sleep_i    = (bus.instr_out == 12'h003);
      bus.pcl_data_i = bus.instr_out[7:0] ^ 8'h5A;
    end
  end

  assign bus.page_i = page;
  assign bus.wake_i = wake;

  // Noise and wake source: wakes after a random 1..20 cycles of SLEEP,
  // and toggles wake randomly while running (must be ignored).
  initial begin
    int cnt;
    int tgt;
    cnt = 0;
    tgt = 5;
    forever begin
      @(negedge clk);
      noise_ctl = 6'($urandom);
      noise_pcl = 8'($urandom);
      if (rst) begin
        wake = 1'b0;
        cnt  = 0;
      end else if (bus.sleeping_o) begin
        cnt++;
        if (cnt >= tgt) begin
          wake = 1'b1;
          cnt  = 0;
          tgt  = $urandom_range(1, 20);
        end else begin
          wake = 1'b0;
        end
      end else begin
        wake = ($urandom_range(0, 9) == 0);
      end
    end
  end

  function automatic logic [11:0] gen_word();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 60)      return {2'b11, 10'($urandom)};
    else if (r < 68) return {3'b101, 9'($urandom)};
    else if (r < 76) return {4'b1001, 8'($urandom)};
    else if (r < 84) return {4'b1000, 8'($urandom)};
    else if (r < 92) return {4'b0111, 8'($urandom)};
    else if (r < 96) return 12'h022;
    else             return 12'h003;
  endfunction

  // Instruction-level reference: walks the program as the ISA defines it.
  function automatic void build_expected(input int n, input logic [1:0] pg);
    logic [10:0] pc;
    logic [10:0] a;
    logic [11:0] w;
    logic [10:0] stk[$];
    int          gap;
    exp_t        e;
    pc  = 11'h7FF;
    gap = 1;
    stk.push_back(11'h000);
    stk.push_back(11'h000);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = pc;
      w = prog[a];
      e.addr = a;
      e.word = w;
      e.gap  = gap;
      exp_q.push_back(e);
      pc  = a + 11'd1;
      gap = 0;
      if (w[11:9] == 3'b101) begin
        pc  = {pg, w[8:0]};
        gap = 1;
      end else if (w[11:8] == 4'b1001) begin
        stk.push_front(a + 11'd1);
        if (stk.size() > 2) void'(stk.pop_back());
        pc  = {pg, 1'b0, w[7:0]};
        gap = 1;
      end else if (w[11:8] == 4'b1000) begin
        if (stk.size() > 1) pc = stk.pop_front();
        else                pc = stk[0];
        gap = 1;
      end else if (w == 12'h022) begin
        pc  = {pg, 1'b0, w[7:0] ^ 8'h5A};
        gap = 1;
      end else if (w[11:8] == 4'b0111 && w[0]) begin
        pc  = a + 11'd2;
        gap = 1;
      end else if (w == 12'h003) begin
        gap = -1;
      end
    end
  endfunction

  // Monitor / scoreboard.
  initial begin
    exp_t        e;
    int          gap;
    logic        prev_en;
    logic [10:0] last;
    logic [10:0] nxt;
    gap     = 0;
    prev_en = 1'b0;
    last    = '0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        check("rst_prog_addr", bus.prog_addr, 11'h7FF);
        check("rst_pc_o", bus.pc_o, 11'h7FF);
        check("rst_exec_valid", bus.exec_valid, 0);
        check("rst_sleeping", bus.sleeping_o, 0);
        check("rst_instr_out", bus.instr_out, 12'h000);
        prev_en = 1'b0;
      end else begin
        if (mon_en) begin
          if (!prev_en) gap = 1;
          if (bus.exec_valid) begin
            if (exp_q.size() == 0) begin
              check("unexpected_exec", 1, 0);
            end else begin
              e   = exp_q.pop_front();
              nxt = e.addr + 11'd1;
              check("instr_out", bus.instr_out, e.word);
              check("pc_o", bus.pc_o, nxt);
              check("sleeping_in_exec", bus.sleeping_o, 0);
              if (e.gap < 0) check("sleep_gap_ge2", (gap >= 2) ? 1 : 0, 1);
              else           check("bubble_gap", gap, e.gap);
              last = e.addr;
            end
            gap = 0;
          end else begin
            gap++;
            check("nop_out", bus.instr_out, 12'h000);
            if (bus.sleeping_o) check("sleep_pc_frozen", bus.pc_o, last + 11'd1);
          end
        end
        prev_en = mon_en;
      end
    end
  end

  // kind 0: random; 1: SLEEP at 001; 2: GOTO 0x055 at 7FF.
  task automatic begin_run(input logic [1:0] pg, input int n, input int kind);
    @(negedge clk);
    #1 mon_en = 1'b0;
    #1 rst = 1'b1;
    page = pg;
    for (int a = 0; a < 2048; a++) prog[a] = gen_word();
    if (kind == 1) begin
      prog[11'h7FF] = 12'hC00;
      prog[11'h000] = 12'hC11;
      prog[11'h001] = 12'h003;
    end else if (kind == 2) begin
      prog[11'h7FF] = {3'b101, 9'h055};
    end
    build_expected(n, pg);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        mon_en = 1'b0;
        done   = 1'b1;
      end
    end
    mon_en = 1'b0;
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Reset asynchronously while the core sleeps (kind 1) or sits in the
  // bubble after a redirect (kind 2).
  task automatic abort_run(input int kind);
    bit found;
    bit seen;
    found = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      #1;
      if (kind == 1 && bus.sleeping_o) found = 1'b1;
      if (kind == 2 && seen && !bus.exec_valid) found = 1'b1;
      if (bus.exec_valid) seen = 1'b1;
    end
    check("abort_point_reached", found, 1);
    mon_en = 1'b0;
    #1 rst = 1'b1;
  endtask

  initial begin
    begin_run(2'd0, 250, 0);
    wait_drain(8000);
    begin_run(2'd1, 50, 1);
    abort_run(1);
    begin_run(2'd2, 50, 2);
    abort_run(2);
    begin_run(2'd3, 250, 0);
    wait_drain(8000);
    begin_run(2'd1, 250, 0);
    wait_drain(8000);
    begin_run(2'd2, 100, 0);
    wait_drain(4000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/execute sequencer for the 12-bit-instruction PIC-style core. It owns the program counter, the two-level call stack and the fetch pipeline. It presents each fetched instruction to the instruction decoder, or a NOP while the pipeline is flushing or asleep. Decoder control outputs and datapath results are fed back to it to redirect the PC (GOTO, CALL, RETLW, PCL write, conditional skip) and to enter and leave SLEEP.

## Interface
Parameters:
- PC_W, 11, program-counter width; 2K-word space; upper two bits come from page_i.
- RESET_VEC, 11'h7FF, first fetch address after reset.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_addr  out  PC_W  program-memory address; equals the PC register.
- instr_in  in  12  program-memory read data; synchronous ROM, valid one cycle after prog_addr.
- instr_out  out  12  instruction to the decoder; 12'h000 (NOP) when exec_valid is 0.
- exec_valid  out  1  instr_out is a real instruction being executed this cycle.
- goto_i, call_i, retlw_i, sleep_i  in  1 each  decoder outputs for instr_out.
- skip_i  in  1  datapath: skip condition of current FSZ/BTFSx instruction is true.
- pcl_wr_i  in  1  current instruction writes PCL.
- pcl_data_i  in  8  value written to PCL.
- page_i  in  2  STATUS page bits (PA1:PA0).
- wake_i  in  1  wake request (WDT time-out or pin change).
- sleeping_o  out  1  core is in SLEEP.
- pc_o  out  PC_W  debug copy of PC.

## Operation
- States: RUN, SLEEP.
- PC holds the fetch address. While an instruction at address A executes, PC = A+1.
- Default in RUN: PC <= PC+1 modulo 2^PC_W (7FF wraps to 000); exec_valid <= 1.
- All control inputs are ignored when exec_valid = 0.
- Redirects, in priority order if more than one input is asserted. Each one also sets exec_valid <= 0 next cycle, discarding the fall-through fetch; this is a 1-cycle bubble:
  - GOTO: PC <= {page_i, instr_out[8:0]}.
  - CALL: push PC (the return address A+1); PC <= {page_i, 1'b0, instr_out[7:0]}.
  - RETLW: PC <= stack1; stack1 <= stack2; stack2 unchanged (underflow repeats stack2).
  - pcl_wr_i: PC <= {page_i, 1'b0, pcl_data_i}.
  - skip_i: PC <= PC+1, skipping the prefetched instruction.
- Push: stack2 <= stack1; stack1 <= PC. A third nested CALL silently overwrites the oldest entry.
- SLEEP:
  - sleep_i with exec_valid moves RUN -> SLEEP. PC is frozen, exec_valid = 0, sleeping_o = 1.
  - wake_i is sampled only in SLEEP. It moves SLEEP -> RUN with exec_valid = 0 for one cycle, then the instruction at PC is executed.
  - wake_i asserted in the same cycle as sleep_i is ignored.
- Reset, asynchronous and usable at any point including mid-SLEEP or mid-flush:
  - PC = RESET_VEC, stack1 = stack2 = 0.
  - State = RUN, exec_valid = 0, instr_out = 12'h000, sleeping_o = 0.

## Timing
- Latency: address to execute is 1 cycle. Straight-line code executes one instruction per cycle.
- GOTO, CALL, RETLW, PCL write and a taken skip each cost 2 cycles, with the second cycle a NOP bubble.
- instr_out is combinational from instr_in and exec_valid. All other outputs are registered.
- Decoder and datapath inputs are sampled at the same edge that updates PC. The decoder feedback path is combinational within one cycle.
- prog_addr changes only on clk edges or on rst assertion.

## Structure
- Shared core package holds:
  - NOP constant 12'h000.
  - RESET_VEC default.
  - The RUN/SLEEP state enum.
  - GOTO/CALL target field widths (9 and 8 bits).
- One sub-module, call_stack: a two-entry shift stack with push/pop ports and an asynchronous reset. The sequencer instantiates it.

## Test plan
- Reset then release -> prog_addr = 7FF, exec_valid = 0 in the first cycle; then 7FF executes, the next fetch is 000, and exec_valid = 1 on the following cycles.
- GOTO 0x055 at address 010 with page_i = 2'b01 -> the next fetch is 0x255; the instruction at 011 is never executed (exec_valid = 0 for one cycle).
- CALL 0x80 at 020, then CALL 0x90, then CALL 0xA0 (page_i = 0), then three RETLW -> returns to 0x91, 0x81, then 0x81 again (overwrite and underflow behaviour).
- BTFSS at 030 with skip_i = 1 -> 031 is discarded and 032 executes; with skip_i = 0, 031 executes with no bubble.
- SLEEP at 040 -> sleeping_o = 1 and PC frozen at 041 for 20 cycles; wake_i pulse -> one bubble cycle, then 041 executes.
- rst asserted mid-SLEEP and separately during a GOTO bubble -> immediate return to the reset values and a restart at 7FF.
